// File: rtl/led_sbox_pkg.sv
// Shared constants and FSM state type for the LED masked S-box layer controller.
package led_sbox_pkg;

    localparam int STATE_W = 64;
    localparam int SB_W    = 8;
    localparam int R_W     = 36;
    localparam int LATENCY = 3;
    localparam int BEATS   = STATE_W / SB_W;
    localparam int CNT_W   = 4;

    // Last enabled beat: final capture happens here, then the controller reports done.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS + LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/led_sbox_layer_ctrl_share_beat_buffer.sv
// Per-share storage: latches the incoming 64-bit share, hands it out one byte
// per beat, and collects the substituted bytes coming back from the datapath.
module share_beat_buffer
    import led_sbox_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [STATE_W-1:0] load_data,
    input  logic [CNT_W-1:0]   beat_sel,
    output logic [SB_W-1:0]    beat_data,
    input  logic               wr_en,
    input  logic [CNT_W-1:0]   wr_idx,
    input  logic [SB_W-1:0]    wr_data,
    output logic [STATE_W-1:0] captured
);

    logic [STATE_W-1:0] latched;

    // Hold the share for the whole run so the caller may change its inputs freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latched <= '0;
        end else if (load) begin
            latched <= load_data;
        end
    end

    // Select the current beat's byte; flush beats (index >= BEATS) feed zeros.
    always_comb begin
        beat_data = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_sel == CNT_W'(i)) begin
                beat_data = latched[i*SB_W +: SB_W];
            end
        end
    end

    // Write one returned byte into its slot; untouched slots keep the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BEATS; i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    captured[i*SB_W +: SB_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/led_sbox_layer_ctrl.sv
// Sequences one LED S-box layer (three Boolean shares) through the shared
// two-S-box masked datapath, one byte per share per enabled beat.
module led_sbox_layer_ctrl
    import led_sbox_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [STATE_W-1:0]   in_sh1,
    input  logic [STATE_W-1:0]   in_sh2,
    input  logic [STATE_W-1:0]   in_sh3,
    output logic                 ready,
    output logic                 done,
    output logic [STATE_W-1:0]   out_sh1,
    output logic [STATE_W-1:0]   out_sh2,
    output logic [STATE_W-1:0]   out_sh3,
    input  logic [2*R_W-1:0]     rnd,
    input  logic                 rnd_valid,
    output logic                 rnd_ack,
    output logic                 sb_en,
    output logic [SB_W-1:0]      sb_in1,
    output logic [SB_W-1:0]      sb_in2,
    output logic [SB_W-1:0]      sb_in3,
    output logic [R_W-1:0]       sb_r1,
    output logic [R_W-1:0]       sb_r2,
    input  logic [SB_W-1:0]      sb_out1,
    input  logic [SB_W-1:0]      sb_out2,
    input  logic [SB_W-1:0]      sb_out3
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             cap_en;
    logic [CNT_W-1:0] cap_idx;

    // Handshake, datapath enable and capture control derived from state and beat count.
    always_comb begin
        ready   = (state == IDLE);
        done    = (state == DONE);
        load    = (state == IDLE) && start;
        sb_en   = (state == RUN) && rnd_valid;
        rnd_ack = sb_en;
        sb_r1   = rnd[R_W-1:0];
        sb_r2   = rnd[2*R_W-1:R_W];
        cap_en  = sb_en && (cnt >= CNT_W'(LATENCY));
        cap_idx = cnt - CNT_W'(LATENCY);
    end

    // Controller FSM and beat counter; the counter only advances when randomness is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (rnd_valid) begin
                        if (cnt == CNT_LAST) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    share_beat_buffer u_buf1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (in_sh1),
        .beat_sel  (cnt),
        .beat_data (sb_in1),
        .wr_en     (cap_en),
        .wr_idx    (cap_idx),
        .wr_data   (sb_out1),
        .captured  (out_sh1)
    );

    share_beat_buffer u_buf2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (in_sh2),
        .beat_sel  (cnt),
        .beat_data (sb_in2),
        .wr_en     (cap_en),
        .wr_idx    (cap_idx),
        .wr_data   (sb_out2),
        .captured  (out_sh2)
    );

    share_beat_buffer u_buf3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (in_sh3),
        .beat_sel  (cnt),
        .beat_data (sb_in3),
        .wr_en     (cap_en),
        .wr_idx    (cap_idx),
        .wr_data   (sb_out3),
        .captured  (out_sh3)
    );

endmodule

// File: tb/tb_led_sbox_layer_ctrl.sv
// Testbench for led_sbox_layer_ctrl with a behavioural 3-stage masked S-box pair.
module tb_led_sbox_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] in_sh1, in_sh2, in_sh3;
    logic        ready, done;
    logic [63:0] out_sh1, out_sh2, out_sh3;
    logic [71:0] rnd;
    logic        rnd_valid, rnd_ack, sb_en;
    logic [7:0]  sb_in1, sb_in2, sb_in3;
    logic [35:0] sb_r1, sb_r2;
    logic [7:0]  sb_out1, sb_out2, sb_out3;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    led_sbox_layer_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_sh1    (in_sh1),
        .in_sh2    (in_sh2),
        .in_sh3    (in_sh3),
        .ready     (ready),
        .done      (done),
        .out_sh1   (out_sh1),
        .out_sh2   (out_sh2),
        .out_sh3   (out_sh3),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .rnd_ack   (rnd_ack),
        .sb_en     (sb_en),
        .sb_in1    (sb_in1),
        .sb_in2    (sb_in2),
        .sb_in3    (sb_in3),
        .sb_r1     (sb_r1),
        .sb_r2     (sb_r2),
        .sb_out1   (sb_out1),
        .sb_out2   (sb_out2),
        .sb_out3   (sb_out3)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[x*4 +: 4];
    endfunction

    function automatic logic [63:0] layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[i*4 +: 4] = sbox4(x[i*4 +: 4]);
        return y;
    endfunction

    function automatic logic [23:0] dp(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [35:0] r1,
                                       input logic [35:0] r2);
        logic [7:0] x, y, o1, o2;
        x  = a ^ b ^ c;
        y  = {sbox4(x[7:4]), sbox4(x[3:0])};
        o1 = r1[7:0];
        o2 = r2[7:0];
        return {o1, o2, y ^ o1 ^ o2};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [71:0] rand72();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    // Behavioural datapath: advances only on enabled edges, never reset.
    logic [23:0] p1, p2, p3;
    always @(posedge clk) begin
        if (sb_en) begin
            p1 <= dp(sb_in1, sb_in2, sb_in3, sb_r1, sb_r2);
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign {sb_out1, sb_out2, sb_out3} = p3;

    task automatic run_op(input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] s3,
                          input logic [63:0] expect_x, input int stall_at, input int stall_len,
                          input int exp_edges, input bit inject, input bit hold_chk,
                          input logic [63:0] hold_val,
                          output logic [63:0] o1, output logic [63:0] o2, output logic [63:0] o3);
        int edges, en, stalled, acks;
        bit got, held_done;
        logic [63:0] got_x, want;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_before_start ready=%b done=%b required ready=1 done=0", ready, done);
        end
        in_sh1 = s1; in_sh2 = s2; in_sh3 = s3;
        start = 1'b1; rnd_valid = 1'b1; rnd = rand72();
        exp_q.push_back(expect_x);
        @(negedge clk);
        start = 1'b0;
        edges = 0; en = 0; stalled = 0; acks = 0; got = 0; held_done = 0;
        while (edges < 60) begin
            if (en == stall_at && stalled < stall_len) begin
                rnd_valid = 1'b0;
                stalled++;
            end else begin
                rnd_valid = 1'b1;
            end
            rnd = rand72();
            if (inject && edges == 2) begin
                start = 1'b1; in_sh1 = ~s1; in_sh2 = s2 ^ 64'h5A5A; in_sh3 = ~s3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            checks++;
            if (ready !== 1'b0 || sb_en !== rnd_valid || rnd_ack !== rnd_valid) begin
                errors++;
                $display("[TB] FAIL run_ctrl edge=%0d ready=%b sb_en=%b rnd_ack=%b required ready=0 sb_en=rnd_ack=%b",
                         edges, ready, sb_en, rnd_ack, rnd_valid);
            end
            checks++;
            if (sb_r1 !== rnd[35:0] || sb_r2 !== rnd[71:36]) begin
                errors++;
                $display("[TB] FAIL rnd_split sb_r1=%h sb_r2=%h required %h %h",
                         sb_r1, sb_r2, rnd[35:0], rnd[71:36]);
            end
            if (hold_chk && !held_done && en == 3) begin
                held_done = 1;
                checks++;
                if ((out_sh1 ^ out_sh2 ^ out_sh3) !== hold_val) begin
                    errors++;
                    $display("[TB] FAIL result_hold got=%h required=%h",
                             out_sh1 ^ out_sh2 ^ out_sh3, hold_val);
                end
            end
            if (rnd_ack === 1'b1) acks++;
            if (rnd_valid) en++;
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL done_timeout edges=%0d required done within 60", edges);
        end
        checks++;
        if (edges != exp_edges) begin
            errors++;
            $display("[TB] FAIL done_latency edges=%0d required=%0d", edges, exp_edges);
        end
        checks++;
        if (acks != 11) begin
            errors++;
            $display("[TB] FAIL rnd_ack_count got=%0d required=11", acks);
        end
        checks++;
        if (ready !== 1'b0 || sb_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_cycle ready=%b sb_en=%b required 0 0", ready, sb_en);
        end
        got_x = out_sh1 ^ out_sh2 ^ out_sh3;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty got=%h required an expected entry", got_x);
        end else begin
            want = exp_q.pop_front();
            if (got_x !== want) begin
                errors++;
                $display("[TB] FAIL result got=%h required=%h", got_x, want);
            end
        end
        o1 = out_sh1; o2 = out_sh2; o3 = out_sh3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b0; rnd = '0;
        in_sh1 = '0; in_sh2 = '0; in_sh3 = '0;
        @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || sb_en !== 1'b0 || rnd_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl ready=%b done=%b sb_en=%b rnd_ack=%b required 1 0 0 0",
                     ready, done, sb_en, rnd_ack);
        end
        checks++;
        if (out_sh1 !== 64'h0 || out_sh2 !== 64'h0 || out_sh3 !== 64'h0 ||
            sb_in1 !== 8'h0 || sb_in2 !== 8'h0 || sb_in3 !== 8'h0) begin
            errors++;
            $display("[TB] FAIL reset_data out=%h/%h/%h sb_in=%h/%h/%h required zeros",
                     out_sh1, out_sh2, out_sh3, sb_in1, sb_in2, sb_in3);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic(output logic [63:0] res);
        logic [63:0] a, b, o1, o2, o3;
        a = rand64(); b = rand64();
        run_op(a, b, 64'h0123456789ABCDEF ^ a ^ b, 64'hC56B90AD3EF84712,
               -1, 0, 11, 0, 0, '0, o1, o2, o3);
        res = o1 ^ o2 ^ o3;
    endtask

    task automatic test_zero_masks();
        logic [63:0] a, b, x1, x2, x3, y1, y2, y3;
        a = rand64(); b = rand64();
        run_op(a, b, a ^ b, 64'hCCCCCCCCCCCCCCCC, -1, 0, 11, 0, 0, '0, x1, x2, x3);
        a = rand64(); b = rand64();
        run_op(a, b, a ^ b, 64'hCCCCCCCCCCCCCCCC, -1, 0, 11, 0, 0, '0, y1, y2, y3);
        checks++;
        if (x1 === y1 || x2 === y2 || x3 === y3) begin
            errors++;
            $display("[TB] FAIL share_randomisation run1=%h/%h/%h run2=%h/%h/%h required all shares differ",
                     x1, x2, x3, y1, y2, y3);
        end
    endtask

    task automatic test_stall();
        logic [63:0] a, b, o1, o2, o3;
        a = rand64(); b = rand64();
        run_op(a, b, 64'h0123456789ABCDEF ^ a ^ b, 64'hC56B90AD3EF84712,
               4, 5, 16, 0, 0, '0, o1, o2, o3);
    endtask

    task automatic test_start_ignored();
        logic [63:0] a, b, o1, o2, o3;
        a = rand64(); b = rand64();
        run_op(a, b, 64'h0123456789ABCDEF ^ a ^ b, 64'hC56B90AD3EF84712,
               -1, 0, 11, 1, 0, '0, o1, o2, o3);
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] a, b, o1, o2, o3, dropped;
        a = rand64(); b = rand64();
        @(negedge clk);
        in_sh1 = a; in_sh2 = b; in_sh3 = 64'hFEDCBA9876543210 ^ a ^ b;
        start = 1'b1; rnd_valid = 1'b1;
        exp_q.push_back(layer(64'hFEDCBA9876543210));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rnd = rand72();
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || sb_en !== 1'b0 || rnd_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_ctrl ready=%b done=%b sb_en=%b rnd_ack=%b required 1 0 0 0",
                     ready, done, sb_en, rnd_ack);
        end
        checks++;
        if (out_sh1 !== 64'h0 || out_sh2 !== 64'h0 || out_sh3 !== 64'h0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_out out=%h/%h/%h required zeros", out_sh1, out_sh2, out_sh3);
        end
        dropped = exp_q.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        a = rand64(); b = rand64();
        run_op(a, b, 64'h0123456789ABCDEF ^ a ^ b, 64'hC56B90AD3EF84712,
               -1, 0, 11, 0, 0, '0, o1, o2, o3);
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, x, o1, o2, o3;
        a = rand64(); b = rand64(); x = rand64();
        run_op(a, b, x ^ a ^ b, layer(x), -1, 0, 11, 0, 0, '0, o1, o2, o3);
        a = rand64(); b = rand64();
        run_op(a, b, 64'h0123456789ABCDEF ^ a ^ b, 64'hC56B90AD3EF84712,
               -1, 0, 11, 0, 1, layer(x), o1, o2, o3);
    endtask

    initial begin
        logic [63:0] r;
        test_reset();
        test_basic(r);
        test_zero_masks();
        test_stall();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sbox_layer_ctrl.md
Name: led_sbox_layer_ctrl

Overview:
Sequences one full LED S-box layer (64-bit state, 3 Boolean shares) through the shared two-S-box masked datapath, 8 bits (two nibbles) per beat.
- Latches the shared state on start and feeds beats in order.
- Supplies 72 fresh random bits per enabled cycle and gates the datapath enable on randomness availability.
- Flushes the pipeline and reassembles the substituted shared state.
- Sits between the LED round controller and the masked S-box pair.

Parameters:
STATE_W, 64, state width per share
SB_W, 8, bits processed per beat (two 4-bit S-boxes)
LATENCY, 3, enabled clock edges from datapath input to datapath output
R_W, 36, refresh bits per S-box per enabled cycle

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request to process in_sh*; accepted only when ready=1
in_sh1  in  64  state share 0
in_sh2  in  64  state share 1
in_sh3  in  64  state share 2
ready  out  1  controller idle, start will be accepted
done  out  1  one-cycle pulse: out_sh* valid
out_sh1  out  64  substituted share 0
out_sh2  out  64  substituted share 1
out_sh3  out  64  substituted share 2
rnd  in  72  fresh randomness
rnd_valid  in  1  rnd usable this cycle
rnd_ack  out  1  rnd consumed this cycle
sb_en  out  1  datapath pipeline enable
sb_in1  out  8  datapath input share 0
sb_in2  out  8  datapath input share 1
sb_in3  out  8  datapath input share 2
sb_r1  out  36  low-nibble S-box refresh
sb_r2  out  36  high-nibble S-box refresh
sb_out1  in  8  datapath output share 0
sb_out2  in  8  datapath output share 1
sb_out3  in  8  datapath output share 2

Behaviour:
- Reset values:
  - state IDLE, ready=1, done=0, sb_en=0, rnd_ack=0.
  - out_sh*=0, input latch=0, cnt=0, sb_in*=0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches in_sh1..3, clears cnt, goes to RUN.
  - ready=1 only in IDLE. start in RUN or DONE is ignored; it is not queued.
- RUN:
  - sb_en = rnd_valid; rnd_ack = sb_en. Both are combinational, and both are 0 outside RUN.
  - sb_r1 = rnd[35:0]; sb_r2 = rnd[71:36]. These pass through every cycle.
  - cnt (4 bits, range 0..BEATS+LATENCY-1) increments only on enabled cycles. BEATS = STATE_W/SB_W = 8.
  - Input: for cnt=c<8, sb_in* = latched share bits [8c+7:8c]. For c>=8 (flush), sb_in* = 0.
  - Capture: on an enabled cycle with c>=LATENCY, sb_out* is written into out_sh* bits [8(c-LATENCY)+7 : 8(c-LATENCY)].
  - A stall (rnd_valid=0) freezes cnt, captures and the datapath. No randomness is consumed and no data moves.
  - The enabled cycle with c=BEATS+LATENCY-1 (=10) performs the final capture and moves to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - out_sh* hold until overwritten by the next run's captures.
- Latency: with rnd_valid held high, done is asserted in the cycle starting 11 edges after the start-accepting edge (BEATS+LATENCY). Each stall cycle adds exactly one cycle.
- Datapath pipeline contents are not reset. Stale contents never reach out_sh*, because captures begin only at c=LATENCY.
- Reset asserted mid-RUN:
  - Immediate return to reset values; the partial result is discarded.
  - The next run is unaffected.
- Shares are never combined: no XOR across share indices anywhere in the block.

Decomposition:
- Package led_sbox_pkg:
  - constants STATE_W, SB_W, R_W, LATENCY, BEATS.
  - FSM state enum {IDLE, RUN, DONE}.
  - CNT_W = 4.
- Sub-module share_beat_buffer, instantiated once per share:
  - 64-bit latch with 8-bit beat select on the input side.
  - 64-bit capture register with indexed byte write on the output side.
- FSM, counter and randomness gating stay in the top module.

Test Plan:
- Unmasked 0x0123456789ABCDEF, split into 3 random shares; rnd_valid=1 -> XOR of out_sh* = 0xC56B90AD3EF84712; done exactly 11 cycles after start; rnd_ack high 11 cycles.
- Unmasked 0x0, random shares -> XOR of out_sh* = 0xCCCCCCCCCCCCCCCC; each share individually differs between two runs with different masks.
- Same stimulus as the first test with rnd_valid low for 5 cycles at cnt=4 -> identical result; done at 16 cycles; sb_en=0 and rnd_ack=0 during the stall.
- start pulsed during RUN with different shares -> ignored; result matches the first request; ready=0 throughout RUN/DONE.
- rst_n low at cnt=6 -> ready=1, done=0, out_sh*=0, sb_en=0 asynchronously; a fresh run afterwards gives the correct result.
- Back-to-back: start asserted in the first IDLE cycle after done -> accepted; second result correct; first result held on out_sh* until overwritten.
